// File: rtl/serial_operand_shifter.sv
// Bit-serial operand/accumulator datapath feeding a serial ALU, with a small register file.
// Optional ACC_ZERO_FLAG_EN adds a zero_flag output reflecting the last completed result.
module serial_operand_shifter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_start,
  input  logic                       reg_shift_en,
  input  logic                       acc_write_en,
  input  logic                       acc_load_en,
  input  logic                       reg_store_en,
  input  logic [$clog2(NREGS)-1:0]   reg_sel,
  input  logic                       imm_sel,
  input  logic [WIDTH-1:0]           imm,
  input  logic                       alu_result_bit,
  output logic                       acc_bit,
  output logic                       opnd_bit,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic                       bit_done,
  output logic                       busy,
`ifdef ACC_ZERO_FLAG_EN
  output logic                       zero_flag,
`endif
  output logic [WIDTH-1:0]           acc_value
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned RSW   = $clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]   reg_file_q [NREGS];
  logic               reg_we_c;
  logic [WIDTH-1:0]   src_c;
  logic               last_c;

`ifdef ACC_ZERO_FLAG_EN
  logic sticky_q, sticky_d;
  logic zero_flag_q, zero_flag_d;
`endif

  assign src_c  = imm_sel ? imm : reg_file_q[reg_sel];
  assign last_c = (state_q == SHIFT) & reg_shift_en & (bit_idx_q == LAST_IDX);

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      acc_q     <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Register file; only written from IDLE by the store strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        reg_file_q[i] <= '0;
      end
    end else if (reg_we_c) begin
      reg_file_q[reg_sel] <= acc_q;
    end
  end

`ifdef ACC_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q    <= 1'b0;
      zero_flag_q <= 1'b1;
    end else begin
      sticky_q    <= sticky_d;
      zero_flag_q <= zero_flag_d;
    end
  end
`endif

  // Next-state logic: start/abort dominates, then shifting, then IDLE load/store
  always_comb begin
    state_d   = state_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    bit_idx_d = bit_idx_q;
    reg_we_c  = 1'b0;
`ifdef ACC_ZERO_FLAG_EN
    sticky_d    = sticky_q;
    zero_flag_d = zero_flag_q;
`endif
    if (alu_start) begin
      opnd_d    = src_c;
      bit_idx_d = '0;
      state_d   = SHIFT;
`ifdef ACC_ZERO_FLAG_EN
      sticky_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (reg_shift_en) begin
            opnd_d = {1'b0, opnd_q[WIDTH-1:1]};
            if (acc_write_en) begin
              acc_d = {alu_result_bit, acc_q[WIDTH-1:1]};
`ifdef ACC_ZERO_FLAG_EN
              sticky_d = sticky_q | alu_result_bit;
`endif
            end
            if (last_c) begin
              state_d   = IDLE;
              bit_idx_d = '0;
`ifdef ACC_ZERO_FLAG_EN
              zero_flag_d = ~(sticky_q | alu_result_bit);
`endif
            end else begin
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          if (acc_load_en) begin
            acc_d = src_c;
          end else if (reg_store_en) begin
            reg_we_c = 1'b1;
          end
        end
      endcase
    end
  end

  assign acc_bit   = acc_q[0];
  assign opnd_bit  = opnd_q[0];
  assign bit_idx   = bit_idx_q;
  assign busy      = (state_q == SHIFT);
  assign acc_value = acc_q;
  // Combinational on purpose: the controller's next-state logic consumes it in the same cycle
  assign bit_done  = last_c;
`ifdef ACC_ZERO_FLAG_EN
  assign zero_flag = zero_flag_q;
`endif

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Self-checking bench for serial_operand_shifter: directed scenarios plus random traffic
// against a behavioural model. Build with ACC_ZERO_FLAG_EN to also check zero_flag.
module tb_serial_operand_shifter;

  localparam int W  = 8;
  localparam int NR = 4;

  logic       clk, rst_n;
  logic       alu_start, reg_shift_en, acc_write_en, acc_load_en, reg_store_en;
  logic [1:0] reg_sel;
  logic       imm_sel;
  logic [7:0] imm;
  logic       alu_result_bit;
  logic       acc_bit, opnd_bit, bit_done, busy;
  logic [2:0] bit_idx;
  logic [7:0] acc_value;
`ifdef ACC_ZERO_FLAG_EN
  logic       zero_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0] m_acc, m_opnd;
  logic [7:0] m_rf [NR];
  int         m_idx;
  bit         m_busy, m_zf, m_sticky;

  serial_operand_shifter #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .alu_start(alu_start), .reg_shift_en(reg_shift_en),
    .acc_write_en(acc_write_en), .acc_load_en(acc_load_en), .reg_store_en(reg_store_en),
    .reg_sel(reg_sel), .imm_sel(imm_sel), .imm(imm), .alu_result_bit(alu_result_bit),
    .acc_bit(acc_bit), .opnd_bit(opnd_bit), .bit_idx(bit_idx), .bit_done(bit_done),
    .busy(busy),
`ifdef ACC_ZERO_FLAG_EN
    .zero_flag(zero_flag),
`endif
    .acc_value(acc_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_opnd = '0; m_idx = 0; m_busy = 0; m_zf = 1; m_sticky = 0;
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
  endtask

  function automatic bit exp_done();
    return m_busy && reg_shift_en && (m_idx == W - 1);
  endfunction

  // Apply the rules for one rising edge given the inputs currently driven
  task automatic model_edge();
    logic [7:0] src;
    if (!rst_n) begin
      model_reset();
      return;
    end
    src = imm_sel ? imm : m_rf[reg_sel];
    if (alu_start) begin
      m_opnd = src; m_idx = 0; m_busy = 1; m_sticky = 0;
    end else if (m_busy) begin
      if (reg_shift_en) begin
        if (m_idx == W - 1) m_zf = !(m_sticky | alu_result_bit);
        if (acc_write_en) begin
          m_acc = (m_acc >> 1) | (8'(alu_result_bit) << (W - 1));
          m_sticky = m_sticky | alu_result_bit;
        end
        m_opnd = m_opnd >> 1;
        if (m_idx == W - 1) begin
          m_busy = 0; m_idx = 0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (acc_load_en) begin
      m_acc = src;
    end else if (reg_store_en) begin
      m_rf[reg_sel] = m_acc;
    end
  endtask

  task automatic compare_all();
    chk("busy", busy, m_busy);
    chk("bit_idx", bit_idx, m_idx);
    chk("acc_value", acc_value, m_acc);
    chk("acc_bit", acc_bit, m_acc[0]);
    chk("opnd_bit", opnd_bit, m_opnd[0]);
    chk("bit_done", bit_done, exp_done());
`ifdef ACC_ZERO_FLAG_EN
    chk("zero_flag", zero_flag, m_zf);
`endif
  endtask

  // One cycle: compare on the falling edge, advance the model on the rising edge
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    alu_start = 0; reg_shift_en = 0; acc_write_en = 0; acc_load_en = 0;
    reg_store_en = 0; reg_sel = 0; imm_sel = 0; imm = 0; alu_result_bit = 0;
  endtask

  int done_c;
  logic [7:0] seq_3c;

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    step(); step();
    chk("reset_acc", acc_value, 8'h00);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1;
    step();

    // Immediate load, store to reg 2, read it back through a register-sourced load
    acc_load_en = 1; imm_sel = 1; imm = 8'hA5; step();
    acc_load_en = 0; #1;
    chk("imm_load", acc_value, 8'hA5);
    reg_store_en = 1; reg_sel = 2; step();
    reg_store_en = 0; acc_load_en = 1; imm_sel = 1; imm = 8'h00; step();
    acc_load_en = 1; imm_sel = 0; reg_sel = 2; step();
    idle_inputs(); #1;
    chk("reg2_readback", acc_value, 8'hA5);

    // Serial pass-through of 0x3C
    seq_3c = 8'h3C;
    alu_start = 1; imm_sel = 1; imm = 8'h3C; step();
    alu_start = 0; imm = 8'h00;
    for (int i = 0; i < W; i++) begin
      reg_shift_en = 1; acc_write_en = 1; alu_result_bit = opnd_bit; #1;
      chk("pt_opnd_seq", opnd_bit, seq_3c[i]);
      chk("pt_bit_done", bit_done, (i == W - 1));
      step();
    end
    idle_inputs(); #1;
    chk("pt_acc", acc_value, 8'h3C);
    chk("pt_busy_after", busy, 1'b0);
    step();

    // Stall at bit_idx 4 for 3 cycles; all-zero result
    alu_start = 1; imm_sel = 1; imm = 8'h81; step();
    alu_start = 0;
    done_c = 0;
    for (int c = 1; c <= 20; c++) begin
      reg_shift_en = (c < 5 || c > 7); acc_write_en = 1; alu_result_bit = 0; #1;
      if (c >= 5 && c <= 7) chk("stall_idx", bit_idx, 3'd4);
      if (bit_done && done_c == 0) done_c = c;
      step();
    end
    chk("stall_done_cycle", done_c, 11);
    chk("stall_acc", acc_value, 8'h00);
`ifdef ACC_ZERO_FLAG_EN
    chk("zf_all_zero", zero_flag, 1'b1);
`endif
    idle_inputs();

    // Single 1 at result bit 7
    alu_start = 1; imm_sel = 1; imm = 8'h00; step();
    alu_start = 0;
    for (int i = 0; i < W; i++) begin
      reg_shift_en = 1; acc_write_en = 1; alu_result_bit = (i == W - 1); step();
    end
    idle_inputs(); #1;
    chk("bit7_acc", acc_value, 8'h80);
`ifdef ACC_ZERO_FLAG_EN
    chk("zf_bit7", zero_flag, 1'b0);
`endif

    // Priority: start beats load; then abort at bit_idx 5
    acc_load_en = 1; imm_sel = 1; imm = 8'h11; step();
    alu_start = 1; acc_load_en = 1; imm = 8'h99; step();
    idle_inputs(); #1;
    chk("prio_acc", acc_value, 8'h11);
    chk("prio_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      reg_shift_en = 1; step();
    end
    reg_shift_en = 0; #1;
    chk("abort_pre_idx", bit_idx, 3'd5);
    chk("abort_pre_opnd", opnd_bit, 1'b0);
    alu_start = 1; imm_sel = 0; reg_sel = 2; reg_shift_en = 1; step();
    idle_inputs(); #1;
    chk("abort_idx", bit_idx, 3'd0);
    chk("abort_opnd", opnd_bit, 1'b1);
    chk("abort_acc", acc_value, 8'h11);

    // Async reset mid-operation at bit_idx 3
    for (int i = 0; i < 3; i++) begin
      reg_shift_en = 1; acc_write_en = 1; alu_result_bit = 1; step();
    end
    #1;
    chk("rst_pre_idx", bit_idx, 3'd3);
    rst_n = 0; #1;
    model_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", bit_idx, 3'd0);
    chk("rst_acc", acc_value, 8'h00);
    chk("rst_done", bit_done, 1'b0);
    step();
    rst_n = 1; idle_inputs(); step();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      alu_start      = ($urandom_range(0, 15) == 0);
      reg_shift_en   = ($urandom_range(0, 3) != 0);
      acc_write_en   = ($urandom_range(0, 3) != 0);
      acc_load_en    = ($urandom_range(0, 5) == 0);
      reg_store_en   = ($urandom_range(0, 5) == 0);
      reg_sel        = 2'($urandom_range(0, 3));
      imm_sel        = 1'($urandom_range(0, 1));
      imm            = 8'($urandom);
      alu_result_bit = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'($urandom_range(0, 1) & n[0]);
      step();
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
